// File: rtl/rvfi_progress_check_if.sv
// RVFI retirement signals consumed by the progress checker.
// The core (or testbench) drives through master; the checker observes through slave.
interface rvfi_progress_check_if #(
  parameter int NRET = 1
);
  logic [NRET-1:0] rvfi_valid;
  logic [NRET-1:0] rvfi_halt;

  modport master (
    output rvfi_valid,
    output rvfi_halt
  );

  modport slave (
    input rvfi_valid,
    input rvfi_halt
  );
endinterface

// File: rtl/rvfi_progress_check.sv
// Liveness/progress checker on the RVFI retirement channels.
// Flags three sticky errors:
//  - err_gap:   once armed, too many consecutive cycles without a retirement or halt
//  - err_pack:  valid channels not packed from channel 0 upward
//  - err_count: too few retirements when the final check strobe arrives
// A halting retirement permanently stops the gap watchdog.
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif

module rvfi_progress_check #(
  parameter int NRET       = `RISCV_FORMAL_NRET,
  parameter int MAX_GAP    = 16,
  parameter int MIN_RETIRE = 1,
  parameter int CNT_W      = 8,
  parameter bit PACK_CHECK = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           trig,
  input  logic                           check,
  rvfi_progress_check_if.slave           rvfi,
  output logic                           armed,
  output logic [$clog2(MAX_GAP+2)-1:0]   gap_cnt,
  output logic [CNT_W-1:0]               ret_cnt,
  output logic                           err_gap,
  output logic                           err_pack,
  output logic                           err_count
);

  localparam int GAP_W = $clog2(MAX_GAP + 2);
  localparam int PC_W  = $clog2(NRET + 1);
  localparam int SUM_W = CNT_W + PC_W;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_R     = CNT_W'(MIN_RETIRE);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP);

  // The count threshold has to be reachable by the saturating counter.
  if (MIN_RETIRE > (2 ** CNT_W) - 1) begin : g_bad_min_retire
    $error("rvfi_progress_check: MIN_RETIRE exceeds the ret_cnt saturation value");
  end

  // HALTED behaves like DONE for the watchdog but still accepts the final check.
  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_HALTED,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]  ret_pc;
  logic [CNT_W-1:0] ret_sum;
  logic             retire;
  logic             halt;
  logic             gap_eval;
  logic [GAP_W-1:0] gap_nxt;
  logic             gap_expire;
  logic             pack_bad;
  logic             count_bad;

  function automatic logic [PC_W-1:0] popcount(input logic [NRET-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NRET; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'(CNT_MAX)) begin
      return CNT_MAX;
    end
    return s[CNT_W-1:0];
  endfunction

  assign ret_pc  = popcount(rvfi.rvfi_valid);
  assign ret_sum = sat_add(ret_cnt, ret_pc);
  assign retire  = |rvfi.rvfi_valid;
  assign halt    = |(rvfi.rvfi_valid & rvfi.rvfi_halt);
  assign armed   = (state == S_ARMED);

  // A simultaneous trig+check from IDLE still gets one armed-style gap evaluation.
  assign gap_eval = (state == S_ARMED) || ((state == S_IDLE) && trig && check);

  // Final check counts retirements landing in the same cycle; DONE ignores it.
  assign count_bad = check && (state != S_DONE) && (ret_sum < MIN_R);

  if (PACK_CHECK && (NRET > 1)) begin : g_pack
    // Any valid channel whose lower neighbour is idle breaks packing.
    always_comb begin
      pack_bad = 1'b0;
      for (int i = 1; i < NRET; i++) begin
        pack_bad = pack_bad | (rvfi.rvfi_valid[i] & ~rvfi.rvfi_valid[i-1]);
      end
    end
  end else begin : g_no_pack
    assign pack_bad = 1'b0;
  end

  // Next-state selection; check has priority over trig and halt.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (check) begin
          state_nxt = S_DONE;
        end else if (trig) begin
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (check) begin
          state_nxt = S_DONE;
        end else if (halt) begin
          state_nxt = S_HALTED;
        end
      end
      S_HALTED: begin
        if (check) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Gap watchdog: count idle cycles, saturate at the limit and raise the expiry.
  always_comb begin
    gap_nxt    = gap_cnt;
    gap_expire = 1'b0;
    if (gap_eval) begin
      if (retire || halt) begin
        gap_nxt = '0;
      end else if (gap_cnt == GAP_LIMIT) begin
        gap_expire = 1'b1;
      end else begin
        gap_nxt = gap_cnt + GAP_W'(1);
      end
    end
    // Outside ARMED the counter is parked at zero.
    if (state_nxt != S_ARMED) begin
      gap_nxt = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counters and sticky error flags; reset overrides every same-cycle event.
  always_ff @(posedge clock) begin
    if (reset) begin
      gap_cnt   <= '0;
      ret_cnt   <= '0;
      err_gap   <= 1'b0;
      err_pack  <= 1'b0;
      err_count <= 1'b0;
    end else begin
      gap_cnt   <= gap_nxt;
      ret_cnt   <= ret_sum;
      err_gap   <= err_gap | gap_expire;
      err_pack  <= err_pack | pack_bad;
      err_count <= err_count | count_bad;
    end
  end

`ifdef FORMAL
  // Property consumed by the formal wrapper: no error may ever be raised.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!err_gap && !err_pack && !err_count);
    end
  end
`endif

endmodule

// File: tb/tb_rvfi_progress_check.sv
// Bench for rvfi_progress_check: four differently parameterised instances share
// reset/trig/check and receive independent retirement vectors. A behavioural model
// of the rules is compared against every instance each cycle, next to a
// table of hand-computed vectors and directed corner-case sequences.
module tb_rvfi_progress_check;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       trig;
  logic       check;
  logic [3:0] vin [4];
  logic [3:0] hin [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Per-instance configuration (index = instance number).
  localparam int C_NRET   [4] = '{1, 2, 4, 4};
  localparam int C_MAXGAP [4] = '{4, 16, 6, 6};
  localparam int C_MINRET [4] = '{1, 3, 5, 5};
  localparam int C_CNTMAX [4] = '{255, 255, 15, 15};
  localparam int C_PACK   [4] = '{1, 1, 1, 0};

  rvfi_progress_check_if #(.NRET(1)) if0 ();
  rvfi_progress_check_if #(.NRET(2)) if1 ();
  rvfi_progress_check_if #(.NRET(4)) if2 ();
  rvfi_progress_check_if #(.NRET(4)) if3 ();

  assign if0.rvfi_valid = vin[0][0:0];
  assign if0.rvfi_halt  = hin[0][0:0];
  assign if1.rvfi_valid = vin[1][1:0];
  assign if1.rvfi_halt  = hin[1][1:0];
  assign if2.rvfi_valid = vin[2];
  assign if2.rvfi_halt  = hin[2];
  assign if3.rvfi_valid = vin[3];
  assign if3.rvfi_halt  = hin[3];

  logic       armed0, eg0, ep0, ec0;
  logic [2:0] gap0;
  logic [7:0] ret0;
  logic       armed1, eg1, ep1, ec1;
  logic [4:0] gap1;
  logic [7:0] ret1;
  logic       armed2, eg2, ep2, ec2;
  logic [2:0] gap2;
  logic [3:0] ret2;
  logic       armed3, eg3, ep3, ec3;
  logic [2:0] gap3;
  logic [3:0] ret3;

  rvfi_progress_check #(.NRET(1), .MAX_GAP(4), .MIN_RETIRE(1), .CNT_W(8), .PACK_CHECK(1'b1)) u0 (
    .clock(clock), .reset(reset), .trig(trig), .check(check), .rvfi(if0.slave),
    .armed(armed0), .gap_cnt(gap0), .ret_cnt(ret0),
    .err_gap(eg0), .err_pack(ep0), .err_count(ec0)
  );
  rvfi_progress_check #(.NRET(2), .MAX_GAP(16), .MIN_RETIRE(3), .CNT_W(8), .PACK_CHECK(1'b1)) u1 (
    .clock(clock), .reset(reset), .trig(trig), .check(check), .rvfi(if1.slave),
    .armed(armed1), .gap_cnt(gap1), .ret_cnt(ret1),
    .err_gap(eg1), .err_pack(ep1), .err_count(ec1)
  );
  rvfi_progress_check #(.NRET(4), .MAX_GAP(6), .MIN_RETIRE(5), .CNT_W(4), .PACK_CHECK(1'b1)) u2 (
    .clock(clock), .reset(reset), .trig(trig), .check(check), .rvfi(if2.slave),
    .armed(armed2), .gap_cnt(gap2), .ret_cnt(ret2),
    .err_gap(eg2), .err_pack(ep2), .err_count(ec2)
  );
  rvfi_progress_check #(.NRET(4), .MAX_GAP(6), .MIN_RETIRE(5), .CNT_W(4), .PACK_CHECK(1'b0)) u3 (
    .clock(clock), .reset(reset), .trig(trig), .check(check), .rvfi(if3.slave),
    .armed(armed3), .gap_cnt(gap3), .ret_cnt(ret3),
    .err_gap(eg3), .err_pack(ep3), .err_count(ec3)
  );

  // Reference model: phase 0 idle, 1 armed, 2 halted, 3 done.
  int m_phase [4];
  int m_gap   [4];
  int m_ret   [4];
  int m_eg    [4];
  int m_ep    [4];
  int m_ec    [4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      int v;
      int h;
      int nr;
      int nxt;
      bit retire;
      bit hlt;
      bit ev;
      v = int'(vin[k]) & ((1 << C_NRET[k]) - 1);
      h = int'(hin[k]) & ((1 << C_NRET[k]) - 1);
      if (reset) begin
        m_phase[k] = 0; m_gap[k] = 0; m_ret[k] = 0;
        m_eg[k] = 0; m_ep[k] = 0; m_ec[k] = 0;
      end else begin
        nr = m_ret[k] + $countones(v);
        if (nr > C_CNTMAX[k]) nr = C_CNTMAX[k];
        retire = (v != 0);
        hlt    = ((v & h) != 0);
        ev     = (m_phase[k] == 1) || (m_phase[k] == 0 && trig && check);
        if (ev) begin
          if (retire || hlt) m_gap[k] = 0;
          else if (m_gap[k] == C_MAXGAP[k]) m_eg[k] = 1;
          else m_gap[k] = m_gap[k] + 1;
        end
        // Packed means the valid mask has the form 2**n - 1.
        if (C_PACK[k] != 0 && v != 0 && (v & (v + 1)) != 0) m_ep[k] = 1;
        if (check && m_phase[k] != 3 && nr < C_MINRET[k]) m_ec[k] = 1;
        nxt = m_phase[k];
        if (m_phase[k] != 3 && check) nxt = 3;
        else if (m_phase[k] == 0 && trig) nxt = 1;
        else if (m_phase[k] == 1 && hlt) nxt = 2;
        if (nxt != 1) m_gap[k] = 0;
        m_phase[k] = nxt;
        m_ret[k]   = nr;
      end
    end
  endtask

  task automatic get_out(input int k, output int a, output int g, output int r,
                         output int eg, output int ep, output int ec);
    case (k)
      0: begin a = int'(armed0); g = int'(gap0); r = int'(ret0); eg = int'(eg0); ep = int'(ep0); ec = int'(ec0); end
      1: begin a = int'(armed1); g = int'(gap1); r = int'(ret1); eg = int'(eg1); ep = int'(ep1); ec = int'(ec1); end
      2: begin a = int'(armed2); g = int'(gap2); r = int'(ret2); eg = int'(eg2); ep = int'(ep2); ec = int'(ec2); end
      default: begin a = int'(armed3); g = int'(gap3); r = int'(ret3); eg = int'(eg3); ep = int'(ep3); ec = int'(ec3); end
    endcase
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      int a, g, r, eg, ep, ec;
      get_out(k, a, g, r, eg, ep, ec);
      chk($sformatf("model_armed[u%0d]", k), a, (m_phase[k] == 1) ? 1 : 0);
      chk($sformatf("model_gap[u%0d]", k), g, m_gap[k]);
      chk($sformatf("model_ret[u%0d]", k), r, m_ret[k]);
      chk($sformatf("model_err_gap[u%0d]", k), eg, m_eg[k]);
      chk($sformatf("model_err_pack[u%0d]", k), ep, m_ep[k]);
      chk($sformatf("model_err_count[u%0d]", k), ec, m_ec[k]);
    end
  endtask

  // One clock: the model consumes the inputs at the edge, outputs are compared 1ns later.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    reset = 1'b0;
    trig  = 1'b0;
    check = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vin[k] = 4'd0;
      hin[k] = 4'd0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    bit rst;
    bit trg;
    bit chk;
    bit v;
    int e_armed;
    int e_gap;
    int e_eg;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int peak;
    for (int k = 0; k < 4; k++) begin
      m_phase[k] = 0; m_gap[k] = 0; m_ret[k] = 0;
      m_eg[k] = 0; m_ep[k] = 0; m_ec[k] = 0;
    end
    clear_inputs();

    // Gap watchdog vectors for u0 (NRET=1, MAX_GAP=4), expectations worked by hand.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 2, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 3, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 4, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 4, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};

    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      reset     = tbl[i].rst;
      trig      = tbl[i].trg;
      check     = tbl[i].chk;
      vin[0][0] = tbl[i].v;
      tick();
      chk($sformatf("tbl%0d_armed", i), int'(armed0), tbl[i].e_armed);
      chk($sformatf("tbl%0d_gap", i), int'(gap0), tbl[i].e_gap);
      chk($sformatf("tbl%0d_err_gap", i), int'(eg0), tbl[i].e_eg);
    end

    // Retirement every 4th cycle keeps the watchdog below its limit.
    do_reset();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    peak = 0;
    for (int i = 0; i < 50; i++) begin
      vin[0] = (i % 4 == 3) ? 4'd1 : 4'd0;
      tick();
      if (int'(gap0) > peak) peak = int'(gap0);
    end
    vin[0] = 4'd0;
    chk("periodic_gap_peak", peak, 3);
    chk("periodic_err_gap", int'(eg0), 0);

    // Check counts same-cycle retirements (u1: NRET=2, MIN_RETIRE=3).
    do_reset();
    vin[1] = 4'b0011;
    tick();
    vin[1] = 4'b0001;
    check  = 1'b1;
    tick();
    clear_inputs();
    chk("count_same_cycle_ret", int'(ret1), 3);
    chk("count_same_cycle_err", int'(ec1), 0);
    do_reset();
    vin[1] = 4'b0011;
    tick();
    vin[1] = 4'b0000;
    check  = 1'b1;
    tick();
    clear_inputs();
    chk("count_short_ret", int'(ret1), 2);
    chk("count_short_err", int'(ec1), 1);

    // Packing: u2 checks, u3 has packing disabled.
    do_reset();
    vin[2] = 4'b0011;
    vin[3] = 4'b0011;
    tick();
    chk("pack_ok_u2", int'(ep2), 0);
    chk("pack_ok_u3", int'(ep3), 0);
    vin[2] = 4'b0101;
    vin[3] = 4'b0101;
    tick();
    clear_inputs();
    chk("pack_bad_u2", int'(ep2), 1);
    chk("pack_bad_u3_disabled", int'(ep3), 0);

    // Halt retirement stops the watchdog for good.
    do_reset();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    vin[0] = 4'd1;
    hin[0] = 4'd1;
    tick();
    vin[0] = 4'd0;
    hin[0] = 4'd0;
    for (int i = 0; i < 100; i++) tick();
    chk("halt_err_gap", int'(eg0), 0);
    chk("halt_gap", int'(gap0), 0);
    chk("halt_armed", int'(armed0), 0);

    // Counter saturation on the CNT_W=4 instance.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      vin[2] = 4'b0001;
      tick();
    end
    vin[2] = 4'd0;
    chk("ret_saturate_u2", int'(ret2), 15);

    // Reset in the middle of a gap with err_gap already raised; trig ignored during reset.
    do_reset();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    vin[0] = 4'd1;
    tick();
    vin[0] = 4'd0;
    for (int i = 0; i < 3; i++) tick();
    chk("midgap_gap_before", int'(gap0), 3);
    chk("midgap_err_before", int'(eg0), 1);
    reset = 1'b1;
    trig  = 1'b1;
    tick();
    chk("midgap_rst_armed", int'(armed0), 0);
    chk("midgap_rst_gap", int'(gap0), 0);
    chk("midgap_rst_err", int'(eg0), 0);
    chk("midgap_rst_ret", int'(ret0), 0);
    tick();
    chk("rst_trig_ignored", int'(armed0), 0);
    clear_inputs();
    tick();
    chk("after_rst_idle", int'(armed0), 0);

    // Randomised traffic on all instances against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      trig  = ($urandom_range(0, 19) == 0);
      check = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 4; k++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6) vin[k] = 4'd0;
        else if (sel < 9) vin[k] = 4'((1 << $urandom_range(0, C_NRET[k])) - 1);
        else vin[k] = 4'($urandom_range(0, 15));
        hin[k] = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      end
      tick();
    end
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
